enet_gmii_tx_arbiter: RTL and testbench

Frame-level arbiter and sequencer for the GMII transmit side of the Ethernet RGMII/GMII bridge. Accepts two independent byte-stream frame sources: requester 0, the TX DMA path, and requester 1, the control/pause/ARP responder. Grants them round-robin at frame boundaries and drives `gmii_tx_en/er/txd` toward the RGMII TX converter. It generates the preamble and SFD, enforces the inter-frame gap, and aborts frames on source underrun or over-length (jabber). Requesters supply destination-MAC-through-FCS bytes only.

---
 rtl/enet_gmii_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_enet_gmii_tx_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/enet_gmii_tx_arbiter.sv
// Round-robin frame arbiter and GMII TX sequencer for two byte-stream requesters.
// Adds preamble/SFD, enforces the inter-frame gap, and aborts on underrun or jabber.
module enet_gmii_tx_arbiter #(
   parameter int IFG_LEN = 12,
   parameter int MAX_LEN = 1518
) (
   input  logic       gmii_tx_clk,
   input  logic       rst,
   input  logic       tx_enable,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   input  logic       req1_last,
   output logic       req1_ready,
   output logic       gmii_tx_en,
   output logic       gmii_tx_er,
   output logic [7:0] gmii_txd,
   output logic       grant,
   output logic       busy,
   output logic       frame_done,
   output logic       underrun,
   output logic       jabber
);

   localparam logic [15:0] MAX_W    = 16'(MAX_LEN);
   localparam logic [15:0] IFG_LAST = 16'(IFG_LEN - 1);

   typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, ERR, DRAIN, IFG} state_t;

   state_t      state, state_nxt;
   logic [2:0]  pre_cnt;
   logic [15:0] byte_cnt;
   logic [15:0] ifg_cnt;
   logic        last_grant;

   logic       g_valid, g_last, room, accept, g_ready, arb_req, arb_pick;
   logic [7:0] g_data;
   logic       en_nxt, er_nxt, frame_done_nxt, underrun_nxt, jabber_nxt;
   logic [7:0] txd_nxt;

   assign g_valid    = grant ? req1_valid : req0_valid;
   assign g_data     = grant ? req1_data  : req0_data;
   assign g_last     = grant ? req1_last  : req0_last;
   assign room       = byte_cnt < MAX_W;
   assign accept     = ((state == SFD) || (state == DATA)) && room;
   assign g_ready    = accept || (state == DRAIN);
   assign req0_ready = g_ready && !grant;
   assign req1_ready = g_ready && grant;
   assign busy       = (state != IDLE);
   assign arb_req    = tx_enable && (req0_valid || req1_valid);
   // On a tie the requester not served last wins; otherwise whoever is asking.
   assign arb_pick   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

   always_ff @(posedge gmii_tx_clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (arb_req) state_nxt = PRE;
         PRE:       if (pre_cnt == 3'd6) state_nxt = SFD;
         SFD, DATA: begin
            if (!room || !g_valid) state_nxt = ERR;
            else if (g_last)       state_nxt = IFG;
            else                   state_nxt = DATA;
         end
         // Both error causes fire before any last byte was accepted, so drain.
         ERR:       state_nxt = DRAIN;
         DRAIN:     if (g_valid && g_last) state_nxt = IFG;
         IFG:       if (!gmii_tx_en && (ifg_cnt == IFG_LAST)) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      en_nxt         = 1'b0;
      er_nxt         = 1'b0;
      txd_nxt        = 8'h00;
      frame_done_nxt = 1'b0;
      underrun_nxt   = 1'b0;
      jabber_nxt     = 1'b0;
      case (state)
         IDLE: begin
            if (arb_req) begin
               en_nxt  = 1'b1;
               txd_nxt = 8'h55;
            end
         end
         PRE: begin
            en_nxt  = 1'b1;
            txd_nxt = (pre_cnt == 3'd6) ? 8'hD5 : 8'h55;
         end
         SFD, DATA: begin
            en_nxt = 1'b1;
            if (!room) begin
               er_nxt     = 1'b1;
               jabber_nxt = 1'b1;
            end else if (!g_valid) begin
               er_nxt       = 1'b1;
               underrun_nxt = 1'b1;
            end else begin
               txd_nxt        = g_data;
               frame_done_nxt = g_last;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge gmii_tx_clk or posedge rst) begin
      if (rst) begin
         pre_cnt    <= 3'd0;
         byte_cnt   <= 16'd0;
         ifg_cnt    <= 16'd0;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         gmii_tx_en <= 1'b0;
         gmii_tx_er <= 1'b0;
         gmii_txd   <= 8'h00;
         frame_done <= 1'b0;
         underrun   <= 1'b0;
         jabber     <= 1'b0;
      end else begin
         if (state == PRE) pre_cnt <= pre_cnt + 3'd1;
         else              pre_cnt <= 3'd0;

         if (state == IDLE)           byte_cnt <= 16'd0;
         else if (accept && g_valid)  byte_cnt <= byte_cnt + 16'd1;

         // Gap counts only cycles where the line is actually idle.
         if (state != IFG)     ifg_cnt <= 16'd0;
         else if (!gmii_tx_en) ifg_cnt <= ifg_cnt + 16'd1;

         if ((state == IDLE) && arb_req) begin
            grant      <= arb_pick;
            last_grant <= arb_pick;
         end

         gmii_tx_en <= en_nxt;
         gmii_tx_er <= er_nxt;
         gmii_txd   <= txd_nxt;
         frame_done <= frame_done_nxt;
         underrun   <= underrun_nxt;
         jabber     <= jabber_nxt;
      end
   end

endmodule

// File: tb/tb_enet_gmii_tx_arbiter.sv
// Directed bench for enet_gmii_tx_arbiter: framing, arbitration, underrun,
// jabber, async reset and tx_enable gating.
module tb_enet_gmii_tx_arbiter;

   logic       gmii_tx_clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_enable = 1'b1;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
   logic       req0_last = 1'b0, req1_last = 1'b0;
   logic       req0_ready, req1_ready;
   logic       gmii_tx_en, gmii_tx_er;
   logic [7:0] gmii_txd;
   logic       grant, busy, frame_done, underrun, jabber;

   int tests = 0;
   int fails = 0;

   // Source queues: {hole, last, data}; a hole entry holds valid low for one cycle.
   logic [9:0] q0[$];
   logic [9:0] q1[$];
   logic [7:0] exp_bytes[$];

   enet_gmii_tx_arbiter #(.IFG_LEN(12), .MAX_LEN(8)) dut (
      .gmii_tx_clk(gmii_tx_clk), .rst(rst), .tx_enable(tx_enable),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last),
      .req1_ready(req1_ready),
      .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er), .gmii_txd(gmii_txd),
      .grant(grant), .busy(busy), .frame_done(frame_done),
      .underrun(underrun), .jabber(jabber)
   );

   always #4 gmii_tx_clk = ~gmii_tx_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
      req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
      if (q0.size() > 0) begin
         req0_valid = !q0[0][9]; req0_data = q0[0][7:0]; req0_last = q0[0][8];
      end
      if (q1.size() > 0) begin
         req1_valid = !q1[0][9]; req1_data = q1[0][7:0]; req1_last = q1[0][8];
      end
   endtask

   // Advance one clock; outputs are sampled 1 ns after the rising edge.
   task automatic step();
      logic h0, h1;
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      @(posedge gmii_tx_clk);
      #1;
      if (q0.size() > 0 && (h0 || q0[0][9])) void'(q0.pop_front());
      if (q1.size() > 0 && (h1 || q1[0][9])) void'(q1.pop_front());
      drive();
   endtask

   task automatic wait_start(output int n);
      n = 0;
      while (gmii_tx_en !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      chk("frame_start", {31'd0, gmii_tx_en}, 32'd1);
   endtask

   task automatic expect_preamble(input string tag, input logic g);
      chk({tag, "_grant"}, {31'd0, grant}, {31'd0, g});
      for (int i = 0; i < 7; i++) begin
         chk({tag, "_pre"}, {gmii_tx_en, gmii_tx_er, gmii_txd}, {1'b1, 1'b0, 8'h55});
         step();
      end
      chk({tag, "_sfd"}, {gmii_tx_en, gmii_tx_er, gmii_txd}, {1'b1, 1'b0, 8'hD5});
      chk({tag, "_rdy_g"}, {31'd0, g ? req1_ready : req0_ready}, 32'd1);
      chk({tag, "_rdy_ng"}, {31'd0, g ? req0_ready : req1_ready}, 32'd0);
      step();
   endtask

   task automatic expect_frame(input string tag, input logic g);
      expect_preamble(tag, g);
      for (int i = 0; i < exp_bytes.size(); i++) begin
         chk({tag, "_data"}, {gmii_tx_en, gmii_tx_er, gmii_txd}, {1'b1, 1'b0, exp_bytes[i]});
         chk({tag, "_done"}, {31'd0, frame_done}, (i == exp_bytes.size() - 1) ? 32'd1 : 32'd0);
         chk({tag, "_jab"}, {31'd0, jabber}, 32'd0);
         step();
      end
      chk({tag, "_after_en"}, {31'd0, gmii_tx_en}, 32'd0);
      chk({tag, "_after_jab"}, {31'd0, jabber}, 32'd0);
   endtask

   task automatic check_ifg(input string tag);
      for (int i = 0; i < 12; i++) begin
         chk({tag, "_ifg_en"}, {31'd0, gmii_tx_en}, 32'd0);
         chk({tag, "_ifg_busy"}, {31'd0, busy}, 32'd1);
         step();
      end
      chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int n;
      drive();
      // Reset state
      @(posedge gmii_tx_clk); #1;
      chk("rst_gmii", {gmii_tx_en, gmii_tx_er, gmii_txd}, 32'd0);
      chk("rst_stat", {grant, busy, frame_done, underrun, jabber, req0_ready, req1_ready}, 32'd0);
      rst = 1'b0;

      // Single 4-byte frame from req0
      q0 = '{10'h011, 10'h022, 10'h033, 10'h144};
      exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
      drive();
      step();
      chk("t1_first_pre", {gmii_tx_en, gmii_txd}, {1'b1, 8'h55});
      expect_frame("t1", 1'b0);
      check_ifg("t1");

      // Round-robin: three 2-byte frames each, starting fresh from reset
      rst = 1'b1; #1; rst = 1'b0;
      for (int f = 0; f < 3; f++) begin
         q0.push_back({2'b00, 8'(8'h01 + 2 * f)});
         q0.push_back({2'b01, 8'(8'h02 + 2 * f)});
         q1.push_back({2'b00, 8'(8'h81 + 2 * f)});
         q1.push_back({2'b01, 8'(8'h82 + 2 * f)});
      end
      drive();
      for (int f = 0; f < 6; f++) begin
         logic g;
         int k;
         g = f[0];
         k = f / 2;
         if (g) exp_bytes = '{8'(8'h81 + 2 * k), 8'(8'h82 + 2 * k)};
         else   exp_bytes = '{8'(8'h01 + 2 * k), 8'(8'h02 + 2 * k)};
         wait_start(n);
         if (f > 0) chk("t2_gap", n, 32'd13);
         expect_frame("t2", g);
      end

      // Underrun: req1 drops valid after 2 of 5 bytes
      q1 = '{10'h0C1, 10'h0C2, 10'h200, 10'h0C3, 10'h0C4, 10'h1C5};
      drive();
      wait_start(n);
      expect_preamble("t3", 1'b1);
      chk("t3_b1", {gmii_tx_en, gmii_tx_er, gmii_txd}, {1'b1, 1'b0, 8'hC1});
      step();
      chk("t3_b2", {gmii_tx_en, gmii_tx_er, gmii_txd}, {1'b1, 1'b0, 8'hC2});
      step();
      chk("t3_err", {gmii_tx_en, gmii_tx_er, gmii_txd}, {1'b1, 1'b1, 8'h00});
      chk("t3_pulses", {underrun, jabber, frame_done}, 32'b100);
      step();
      for (int i = 0; i < 3; i++) begin
         chk("t3_drain", {gmii_tx_en, underrun, req1_ready, req0_ready}, 32'b0010);
         step();
      end
      chk("t3_q_empty", q1.size(), 32'd0);
      check_ifg("t3");

      // Jabber with MAX_LEN=8: 10-byte frame from req0
      for (int i = 0; i < 10; i++) q0.push_back({1'b0, (i == 9), 8'(8'h31 + i)});
      drive();
      wait_start(n);
      expect_preamble("t4", 1'b0);
      for (int i = 0; i < 8; i++) begin
         chk("t4_data", {gmii_tx_en, gmii_tx_er, gmii_txd}, {1'b1, 1'b0, 8'(8'h31 + i)});
         step();
      end
      chk("t4_err", {gmii_tx_en, gmii_tx_er, gmii_txd}, {1'b1, 1'b1, 8'h00});
      chk("t4_pulses", {underrun, jabber, frame_done}, 32'b010);
      step();
      for (int i = 0; i < 2; i++) begin
         chk("t4_drain", {gmii_tx_en, jabber, req0_ready}, 32'b001);
         step();
      end
      check_ifg("t4");

      // Exactly MAX_LEN bytes with last on byte 8 is a good frame
      exp_bytes.delete();
      for (int i = 0; i < 8; i++) begin
         q0.push_back({1'b0, (i == 7), 8'(8'h41 + i)});
         exp_bytes.push_back(8'(8'h41 + i));
      end
      drive();
      wait_start(n);
      expect_frame("t4b", 1'b0);

      // Asynchronous reset in the middle of a 6-byte frame
      for (int i = 0; i < 6; i++) q0.push_back({1'b0, (i == 5), 8'(8'h51 + i)});
      drive();
      wait_start(n);
      for (int i = 0; i < 9; i++) step();
      chk("t5_mid", {gmii_tx_en, gmii_tx_er, gmii_txd}, {1'b1, 1'b0, 8'h52});
      rst = 1'b1;
      #1;
      chk("t5_rst_gmii", {gmii_tx_en, gmii_tx_er, gmii_txd}, 32'd0);
      chk("t5_rst_stat", {grant, busy, frame_done, underrun, jabber, req0_ready, req1_ready}, 32'd0);
      @(posedge gmii_tx_clk); #1;
      rst = 1'b0;
      q0.delete();
      exp_bytes.delete();
      for (int i = 0; i < 6; i++) begin
         q0.push_back({1'b0, (i == 5), 8'(8'h71 + i)});
         exp_bytes.push_back(8'(8'h71 + i));
      end
      drive();
      wait_start(n);
      chk("t5_restart_lat", n, 32'd1);
      expect_frame("t5", 1'b0);

      // tx_enable gating
      tx_enable = 1'b0;
      q0 = '{10'h061, 10'h162};
      exp_bytes = '{8'h61, 8'h62};
      drive();
      for (int i = 0; i < 20; i++) step();
      for (int i = 0; i < 3; i++) begin
         chk("t6_held", {gmii_tx_en, busy, req0_ready}, 32'd0);
         step();
      end
      tx_enable = 1'b1;
      step();
      chk("t6_start", {gmii_tx_en, gmii_txd}, {1'b1, 8'h55});
      tx_enable = 1'b0;
      expect_frame("t6", 1'b0);
      check_ifg("t6");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
